// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
//
// Time-multiplexes a multi-digit BCD value onto one shared 4-bit digit bus
// with one-hot digit enables. This block sits in front of the 7-segment
// decoder. New values arrive through a valid/ready handshake into a one-entry
// pending buffer. They move into the shown register only at a frame boundary,
// so one scan never mixes two values. Invalid digits (>9) and, optionally,
// leading zeros are emitted as 4'hF. The decoder renders 4'hF as blank.
//
// Parameters
//   NUM_DIGITS    number of multiplexed digits (1..8)
//   REFRESH_DIV   clock cycles each digit stays enabled (>= 1)
//   BLANK_LEADING 1 = blank leading zeros, 0 = show every digit
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    in_bcd carries a new value
//   in_ready    pending buffer empty; transfer on in_valid && in_ready
//   in_bcd      BCD digits, digit i = in_bcd[4i+3:4i], digit 0 = LSD
//   digit_data  nibble for the enabled digit, 4'hF = blank
//   digit_sel   one-hot, active-high enable of the current digit
//   frame_done  one-cycle pulse on the last cycle of each full scan
// ---------------------------------------------------------------------------
module bcd_display_scanner #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 1000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*NUM_DIGITS-1:0] in_bcd,
   output logic [3:0]              digit_data,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);

   // Widths are kept at least 1 so that the degenerate settings
   // REFRESH_DIV=1 and NUM_DIGITS=1 still produce legal vectors.
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           prescaler;
   logic [IW-1:0]           index;
   logic [4*NUM_DIGITS-1:0] shown;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pending_full;

   logic                    pre_wrap;
   logic                    idx_last;
   logic                    accept;

   logic [NUM_DIGITS-1:0]   digit_zero;
   logic [NUM_DIGITS-1:0]   upper_zero;
   logic [3:0]              cur_digit;
   logic                    cur_leading;

   assign pre_wrap   = (prescaler == PRE_LAST);
   assign idx_last   = (index == IDX_LAST);
   assign frame_done = pre_wrap && idx_last;
   assign in_ready   = !pending_full;
   assign accept     = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Scan timing
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         index     <= '0;
      end else begin
         if (pre_wrap) begin
            prescaler <= '0;
            if (idx_last) begin
               index <= '0;
            end else begin
               index <= index + 1'b1;
            end
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Pending buffer and frame-boundary swap.
   // The swap and an accept are mutually exclusive. A swap needs
   // pending_full=1, and an accept needs in_ready=1, which means
   // pending_full=0. A value accepted on a boundary edge therefore
   // lands in pending and waits for the following boundary.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shown        <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
      end else begin
         if (frame_done && pending_full) begin
            shown        <= pending;
            pending_full <= 1'b0;
         end else if (accept) begin
            pending      <= in_bcd;
            pending_full <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Leading-zero detection.
   // upper_zero[i] is set when digits i..NUM_DIGITS-1 are all exactly
   // zero. An invalid nibble (>9) is nonzero, so it stops the blanking
   // run.
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_zero[i] = (shown[4*i +: 4] == 4'd0);
      end
   end

   always_comb begin
      logic run;
      run        = 1'b1;
      upper_zero = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run           = run & digit_zero[i];
         upper_zero[i] = run;
      end
   end

   // ------------------------------------------------------------------
   // Digit mux. Digit 0 is never treated as leading, so a value of all
   // zeros still shows a single 0.
   // ------------------------------------------------------------------
   always_comb begin
      cur_digit   = 4'd0;
      cur_leading = 1'b0;
      digit_sel   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (index == IW'(i)) begin
            digit_sel[i] = 1'b1;
            cur_digit    = shown[4*i +: 4];
            cur_leading  = (i != 0) && upper_zero[i];
         end
      end
   end

   always_comb begin
      if (cur_digit > 4'd9) begin
         digit_data = 4'hF;
      end else if ((BLANK_LEADING != 0) && cur_leading) begin
         digit_data = 4'hF;
      end else begin
         digit_data = cur_digit;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// Bench for bcd_display_scanner with NUM_DIGITS=4, REFRESH_DIV=4 and
// BLANK_LEADING=1. The stimulus process pushes the expected digit pattern of
// each complete frame into exp_q. Slot i of a pattern sits in bits [4i+3:4i].
// A monitor samples the DUT on the falling edge. It checks the scan timing
// against its own cycle count, collects the digit_data of every slot, and
// pops and compares one pattern each time frame_done pulses.
// ---------------------------------------------------------------------------
module tb_bcd_display_scanner;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_bcd = '0;
   logic [3:0]  digit_data;
   logic [3:0]  digit_sel;
   logic        frame_done;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;

   logic [15:0] exp_q[$];

   bcd_display_scanner #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .BLANK_LEADING(1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .digit_data(digit_data),
      .digit_sel (digit_sel),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %h required %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          mon_c = 0;
   int          slot;
   logic [15:0] obs = '0;
   logic [15:0] exp_frame;
   logic [3:0]  exp_sel;

   always @(negedge clk) begin
      if (reset) begin
         mon_c = 0;
         obs   = '0;
      end else begin
         slot    = (mon_c >> 2) & 3;
         exp_sel = 4'b0001 << slot;
         check("digit_sel", {28'd0, digit_sel}, {28'd0, exp_sel});
         check("frame_done", {31'd0, frame_done}, {31'd0, ((mon_c % 16) == 15)});
         if ((mon_c % 4) == 0) begin
            obs[slot*4 +: 4] = digit_data;
         end else begin
            check("digit_stable", {28'd0, digit_data}, {28'd0, obs[slot*4 +: 4]});
         end
         if (frame_done) begin
            if (exp_q.size() == 0) begin
               check("frame_unexpected", {16'd0, obs}, 32'hFFFF_FFFF);
            end else begin
               exp_frame = exp_q.pop_front();
               check("frame", {16'd0, obs}, {16'd0, exp_frame});
            end
         end
         mon_c++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int k);
      while (cyc < k) step();
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic drive(input int k, input logic [15:0] v);
      goto(k);
      in_valid = 1'b1;
      in_bcd   = v;
      step();
      in_valid = 1'b0;
      in_bcd   = 16'($urandom);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;

      // Reset values while reset is held.
      #12;
      check("rst_sel", {28'd0, digit_sel}, 32'h1);
      check("rst_data", {28'd0, digit_data}, 32'h0);
      check("rst_frame_done", {31'd0, frame_done}, 32'h0);
      check("rst_in_ready", {31'd0, in_ready}, 32'h1);

      // Idle frame, then 1234, then the leading-zero and invalid-digit loads.
      do_reset();
      exp_q.push_back(16'hFFF0);
      exp_q.push_back(16'h1234);
      drive(2, 16'h1234);
      check("s2_ready_c3", {31'd0, in_ready}, 32'h0);
      goto(15);
      check("s2_ready_c15", {31'd0, in_ready}, 32'h0);
      goto(16);
      check("s2_ready_c16", {31'd0, in_ready}, 32'h1);
      exp_q.push_back(16'hFF50);
      drive(17, 16'h0050);
      exp_q.push_back(16'hFFF0);
      drive(33, 16'h0000);
      exp_q.push_back(16'h1000);
      drive(49, 16'h1000);
      exp_q.push_back(16'h1F2F);
      drive(65, 16'h1A2B);
      goto(96);
      check("s3_drained", exp_q.size(), 0);

      // Back-pressure: 1111 is accepted in cycle 1, and 2222 is held until
      // the buffer frees at cycle 16.
      do_reset();
      exp_q.push_back(16'hFFF0);
      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
      goto(1);
      in_valid = 1'b1;
      in_bcd   = 16'h1111;
      step();
      in_bcd = 16'h2222;
      check("s4_ready_c2", {31'd0, in_ready}, 32'h0);
      goto(16);
      check("s4_ready_c16", {31'd0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      check("s4_ready_c17", {31'd0, in_ready}, 32'h0);
      goto(48);

      // Reset mid-frame while the pending buffer is full.
      do_reset();
      exp_q.push_back(16'hFFF0);
      drive(2, 16'h5678);
      drive(17, 16'h9999);
      goto(22);
      check("s6_ready_pre", {31'd0, in_ready}, 32'h0);
      reset = 1'b1;
      #1;
      check("s6_rst_sel", {28'd0, digit_sel}, 32'h1);
      check("s6_rst_data", {28'd0, digit_data}, 32'h0);
      check("s6_rst_frame_done", {31'd0, frame_done}, 32'h0);
      check("s6_rst_ready", {31'd0, in_ready}, 32'h1);
      do_reset();
      exp_q.push_back(16'hFFF0);
      exp_q.push_back(16'hFFF0);
      goto(5);
      check("s6_ready_c5", {31'd0, in_ready}, 32'h1);
      goto(20);
      check("s6_ready_c20", {31'd0, in_ready}, 32'h1);
      goto(32);

      guard = 0;
      while (exp_q.size() != 0 && guard < 40) begin
         step();
         guard++;
      end
      check("final_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "timeout");
   end

endmodule
